// File: rtl/clk_div_ctrl_if.sv
// Divide-select configuration handshake between a requester and clk_div_ctrl.
interface clk_div_ctrl_if #(
  parameter int SEL_W = 2
);
  logic             cfg_valid;
  logic [SEL_W-1:0] cfg_sel;
  logic             cfg_ready;

  modport master (output cfg_valid, output cfg_sel, input  cfg_ready);
  modport slave  (input  cfg_valid, input  cfg_sel, output cfg_ready);
endinterface

// File: rtl/clk_div_ctrl.sv
// Power-of-two clock divider sequencer: glitch-free ratio changes at period boundaries plus a per-period strobe.
// Optional status counter of applied select changes is enabled with `define CLK_DIV_CTRL_STATUS_EN.
module clk_div_ctrl #(
  parameter int CNT_W     = 4,
  parameter int SEL_W     = 2,
  parameter int RESET_SEL = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  clk_div_ctrl_if.slave    cfg,
  output logic [SEL_W-1:0] cur_sel,
  output logic             div_clk,
  output logic             div_ce,
  output logic             busy
`ifdef CLK_DIV_CTRL_STATUS_EN
  ,
  output logic [7:0]       sw_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, SWITCH} state_t;

  localparam int               RST_SEL_I = (RESET_SEL >= CNT_W) ? CNT_W - 1 : RESET_SEL;
  localparam logic [SEL_W-1:0] RST_SEL_C = SEL_W'(RST_SEL_I);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [SEL_W-1:0] cur_sel_nxt;
  logic [SEL_W-1:0] pend_sel, pend_sel_nxt;
  logic             div_ce_nxt;
  logic             wrap;
  logic             xfer;
  logic [CNT_W-1:0] sel_bit;

  function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] s);
    if (int'(s) >= CNT_W) clamp_sel = SEL_W'(CNT_W - 1);
    else                  clamp_sel = s;
  endfunction

  // Terminal count P-1 for a (clamped) select: sel+1 low bits set.
  function automatic logic [CNT_W-1:0] last_cnt(input logic [SEL_W-1:0] s);
    logic [CNT_W-1:0] ones;
    ones     = '1;
    last_cnt = ones >> (CNT_W - 1 - int'(s));
  endfunction

  assign wrap          = (cnt == last_cnt(cur_sel));
  assign sel_bit       = CNT_W'(1) << cur_sel;
  assign div_clk       = |(cnt & sel_bit);
  assign cfg.cfg_ready = (state != SWITCH);
  assign xfer          = cfg.cfg_valid & cfg.cfg_ready;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      cur_sel  <= RST_SEL_C;
      pend_sel <= '0;
      div_ce   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      cur_sel  <= cur_sel_nxt;
      pend_sel <= pend_sel_nxt;
      div_ce   <= div_ce_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    cur_sel_nxt  = cur_sel;
    pend_sel_nxt = pend_sel;
    div_ce_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (xfer) cur_sel_nxt = clamp_sel(cfg.cfg_sel);
        if (en)   state_nxt   = RUN;
      end
      RUN: begin
        cnt_nxt    = wrap ? '0 : cnt + 1'b1;
        div_ce_nxt = wrap;
        // A transfer wins over stopping; the new select waits for the next boundary.
        if (xfer) begin
          pend_sel_nxt = clamp_sel(cfg.cfg_sel);
          state_nxt    = SWITCH;
        end else if (wrap && !en) begin
          state_nxt = IDLE;
        end
      end
      SWITCH: begin
        cnt_nxt    = wrap ? '0 : cnt + 1'b1;
        div_ce_nxt = wrap;
        if (wrap) begin
          cur_sel_nxt = pend_sel;
          state_nxt   = en ? RUN : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef CLK_DIV_CTRL_STATUS_EN
  logic sw_applied;
  assign sw_applied = ((state == IDLE) && xfer) || ((state == SWITCH) && wrap);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                            sw_cnt <= 8'h00;
    else if (sw_applied && sw_cnt != 8'hFF)  sw_cnt <= sw_cnt + 8'h01;
  end
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Randomized and directed bench for clk_div_ctrl with a period-level reference model and scoreboard.
module tb_clk_div_ctrl;
  localparam int CNT_W     = 4;
  localparam int SEL_W     = 3;
  localparam int RESET_SEL = 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             en;
  logic [SEL_W-1:0] cur_sel;
  logic             div_clk, div_ce, busy;
`ifdef CLK_DIV_CTRL_STATUS_EN
  logic [7:0]       sw_cnt;
`endif

  clk_div_ctrl_if #(.SEL_W(SEL_W)) cfg_bus ();

  clk_div_ctrl #(.CNT_W(CNT_W), .SEL_W(SEL_W), .RESET_SEL(RESET_SEL)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .cfg     (cfg_bus.slave),
    .cur_sel (cur_sel),
    .div_clk (div_clk),
    .div_ce  (div_ce),
    .busy    (busy)
`ifdef CLK_DIV_CTRL_STATUS_EN
    ,
    .sw_cnt  (sw_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int dclk;
    int ce;
    int bsy;
    int rdy;
    int sel;
    int sw;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: running flag, position within the period, ratio select, pending request.
  bit m_run, m_pend_v, m_ce;
  int m_pend, m_sel, m_pos, m_sw;
  bit rst_q, en_q, v_q;
  int s_q;

  function automatic int clampm(int s);
    return (s >= CNT_W) ? CNT_W - 1 : s;
  endfunction

  task automatic model_reset();
    m_run = 0; m_pend_v = 0; m_pend = 0; m_pos = 0; m_ce = 0; m_sw = 0;
    m_sel = clampm(RESET_SEL);
  endtask

  task automatic model_step(input bit e, input bit v, input int s);
    int  p;
    bit  at_end;
    p      = 2 << m_sel;
    at_end = (m_pos == p - 1);
    if (!m_run) begin
      m_ce  = 0;
      m_pos = 0;
      if (v) begin
        m_sel = clampm(s);
        if (m_sw < 255) m_sw++;
      end
      if (e) m_run = 1;
    end else begin
      m_ce  = at_end;
      m_pos = at_end ? 0 : m_pos + 1;
      if (m_pend_v) begin
        if (at_end) begin
          m_sel    = m_pend;
          m_pend_v = 0;
          if (m_sw < 255) m_sw++;
          if (!e) m_run = 0;
        end
      end else if (v) begin
        m_pend   = clampm(s);
        m_pend_v = 1;
      end else if (at_end && !e) begin
        m_run = 0;
      end
    end
  endtask

  task automatic push_expected();
    exp_t x;
    int   p;
    p      = 2 << m_sel;
    x.dclk = (m_pos >= p / 2) ? 1 : 0;
    x.ce   = m_ce;
    x.bsy  = (m_run || m_pend_v) ? 1 : 0;
    x.rdy  = m_pend_v ? 0 : 1;
    x.sel  = m_sel;
    x.sw   = m_sw;
    sb.push_back(x);
  endtask

  // One clock: advance the model over the edge, then drive the next inputs and publish expectations.
  task automatic cyc(input bit rn, input bit e, input bit v, input int s);
    @(posedge clk);
    if (rst_q) model_step(en_q, v_q, s_q);
    #1;
    reset_n           = rn;
    en                = e;
    cfg_bus.cfg_valid = v;
    cfg_bus.cfg_sel   = SEL_W'(s);
    rst_q = rn; en_q = e; v_q = v; s_q = s & ((1 << SEL_W) - 1);
    if (!rn) model_reset();
    push_expected();
  endtask

  task automatic check1(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        check1("div_clk",   int'(div_clk),           x.dclk);
        check1("div_ce",    int'(div_ce),            x.ce);
        check1("busy",      int'(busy),              x.bsy);
        check1("cfg_ready", int'(cfg_bus.cfg_ready), x.rdy);
        check1("cur_sel",   int'(cur_sel),           x.sel);
`ifdef CLK_DIV_CTRL_STATUS_EN
        check1("sw_cnt",    int'(sw_cnt),            x.sw);
`endif
      end
    end
  end

  initial begin
    reset_n = 1'b0; en = 1'b1; cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_sel = SEL_W'(2);
    rst_q = 0; en_q = 1; v_q = 1; s_q = 2;
    model_reset();

    // Reset held while en and cfg_valid are active.
    repeat (3) cyc(0, 1, 1, 2);

    // Select 0 and enable in the same IDLE cycle: divide by 2.
    cyc(1, 1, 1, 0);
    repeat (9) cyc(1, 1, 0, 0);

    // Move to P=16, then request select 1 at count 5.
    cyc(1, 1, 1, 3);
    for (int i = 0; i < 200 && !(m_sel == 3 && !m_pend_v && m_pos == 5); i++) cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 1);
    repeat (30) cyc(1, 1, 0, 0);

    // P=8, drop en at count 2: finishes the period, then idles.
    cyc(1, 1, 1, 2);
    for (int i = 0; i < 200 && !(m_sel == 2 && !m_pend_v && m_pos == 2); i++) cyc(1, 1, 0, 0);
    repeat (12) cyc(1, 0, 0, 0);

    // Pending switch discarded by a reset pulse at count 9.
    cyc(1, 1, 1, 3);
    repeat (2) cyc(1, 1, 0, 0);
    for (int i = 0; i < 200 && !(m_sel == 3 && !m_pend_v && m_pos == 1); i++) cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 0);
    for (int i = 0; i < 200 && !(m_pend_v && m_pos == 9); i++) cyc(1, 1, 0, 0);
    repeat (2) cyc(0, 1, 0, 0);
    repeat (20) cyc(1, 1, 0, 0);

    // Out-of-range select 7 clamps to 3.
    repeat (40) cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 7);
    repeat (40) cyc(1, 1, 0, 0);

    // 300 IDLE transfers saturate the switch counter.
    repeat (40) cyc(1, 0, 0, 0);
    repeat (300) cyc(1, 0, 1, $urandom_range(0, 7));

    // Random traffic with occasional resets.
    repeat (3000) cyc(($urandom_range(0, 499) != 0), ($urandom_range(0, 7) != 0),
                      ($urandom_range(0, 5) == 0), $urandom_range(0, 7));
    repeat (3) cyc(1, 0, 0, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    check1("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
